mem_port_arbiter: RTL

//  Shares one 8x8 register-file memory (registered 1-cycle read, separate rd/wr ports)

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_rr2.sv | 34 +++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and defaults for the two-port memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Arbiter ownership states: free arbitration, or locked to one port
  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Default memory geometry (8 entries of 8 bits)
  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  // Requester index: 0 = host, 1 = sort engine
  typedef logic port_idx_t;

endpackage

`default_nettype wire

// File: rtl/arb_rr2.sv
// ============================================================================
//  Module   : arb_rr2
//  Purpose  : Two-way round-robin picker. The mask limits which requests may
//             win; prio breaks ties when both masked requests are present.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  prio,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] eligible;

  assign eligible = req & mask;

  // One-hot (or zero) grant: a lone request wins, a tie goes to prio
  always_comb begin
    gnt = 2'b00;
    if (eligible == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end else begin
      gnt = eligible;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one register-file memory (registered 1-cycle read) between
//             a host port (0) and a sort-engine port (1), one access per cycle,
//             round-robin fair.
//  Options  : ARB_LOCK_EN - enables lock0/lock1 ownership holding for
//             read-modify-write, bounded by HOLD_MAX owned cycles.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_rdaddr,
  output logic [ADDR_W-1:0] mem_wraddr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  logic [1:0]        mask;
  logic [1:0]        pick;
  logic [1:0]        gnt;
  port_idx_t         prio;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              any_gnt;

`ifdef ARB_LOCK_EN
  localparam int HOLD_CNT_W = $clog2(HOLD_MAX + 1);

  arb_state_t            state;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  hold_done;

  assign hold_done = (hold_cnt == HOLD_CNT_W'(HOLD_MAX));

  // While locked only the owning port is eligible
  always_comb begin
    mask = 2'b11;
    case (state)
      OWN0:    mask = 2'b01;
      OWN1:    mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end
`else
  // Lock inputs have no effect when locking is not built in
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
  assign mask        = 2'b11;
`endif

  arb_rr2 u_pick (
    .req  ({req1, req0}),
    .prio (prio),
    .mask (mask),
    .gnt  (pick)
  );

  // No grant is issued while reset is asserted
  assign gnt     = nrst ? pick : 2'b00;
  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign any_gnt = gnt[0] | gnt[1];

  // Memory mux: route the granted port's command; idle cycles drive zeros
  always_comb begin
    sel_we     = gnt[1] ? we1    : we0;
    sel_addr   = gnt[1] ? addr1  : addr0;
    sel_wdata  = gnt[1] ? wdata1 : wdata0;
    mem_rd     = any_gnt & ~sel_we;
    mem_wr     = any_gnt &  sel_we;
    mem_rdaddr = mem_rd ? sel_addr  : '0;
    mem_wraddr = mem_wr ? sel_addr  : '0;
    mem_in     = mem_wr ? sel_wdata : '0;
  end

  // Both ports see the memory output; each qualifies it with its own rvalid
  assign rdata0 = mem_out;
  assign rdata1 = mem_out;

  // Read-valid pipeline: one cycle after each accepted read, never blocked
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt[0] & ~we0;
      rvalid1 <= gnt[1] & ~we1;
    end
  end

`ifdef ARB_LOCK_EN
  // Ownership FSM with fairness pointer and bounded lock hold counter
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= ARB;
      prio     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (any_gnt) begin
        prio <= gnt[0] ? 1'b1 : 1'b0;
      end
      case (state)
        ARB: begin
          if (gnt[0] && lock0) begin
            state    <= OWN0;
            hold_cnt <= HOLD_CNT_W'(1);
          end else if (gnt[1] && lock1) begin
            state    <= OWN1;
            hold_cnt <= HOLD_CNT_W'(1);
          end
        end
        OWN0: begin
          if (hold_done || (gnt[0] && !lock0)) begin
            state    <= ARB;
            prio     <= 1'b1;
            hold_cnt <= '0;
          end else if (!req0 && !lock0) begin
            state    <= ARB;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
          end
        end
        OWN1: begin
          if (hold_done || (gnt[1] && !lock1)) begin
            state    <= ARB;
            prio     <= 1'b0;
            hold_cnt <= '0;
          end else if (!req1 && !lock1) begin
            state    <= ARB;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
          end
        end
        default: begin
          state    <= ARB;
          hold_cnt <= '0;
        end
      endcase
    end
  end
`else
  // Pure round-robin: priority passes to the other port after each access
  always_ff @(posedge clk) begin
    if (!nrst) begin
      prio <= 1'b0;
    end else if (any_gnt) begin
      prio <= gnt[0] ? 1'b1 : 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire
